square_voice_bank_dac: RTL and testbench

- Parametrised N-voice square-wave tone bank with a mixer and an on-chip audio DAC serializer, all in one clock domain.
- Each voice is loaded with a half-period and an amplitude by the note sequencers. The voices are summed into one signed sample, which is shifted out MSB-first on both channels.
- Replaces the fixed two-voice tone and serializer logic. It generalises voice count and sample width, runs on a single clock with no derived clocks, and adds phase-reset note loading and clip detection.

---
 rtl/square_voice_bank_dac.sv | 217 +++++++++++++++++++++
 tb/tb_square_voice_bank_dac.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_voice_bank_dac.sv
// square_voice_bank_dac: N-voice square-wave tone bank, mixer and audio DAC
// serializer, all on one clock.
//
// Build option: define MIX_SATURATE_EN to clamp the mix to the signed
// SAMPLE_W range and report clamping on clip. Left undefined, the mix wraps
// (two's complement) and clip stays 0.
//
// Ports:
//   CLOCK_50_B5B   in   system clock
//   RESET_N        in   asynchronous active-low reset
//   voice_period   in   packed half-periods, voice i at [i*PERIOD_W +: PERIOD_W]
//   voice_amp      in   packed unsigned amplitudes, voice i at [i*AMP_W +: AMP_W]
//   voice_load     in   per-voice pulse: latch period/amp, restart phase high
//   voice_enable   in   per-voice level; 0 mutes the voice in the mix
//   AUD_XCK        out  codec master clock
//   AUD_BCLK       out  bit clock
//   AUD_DACLRCK    out  word select, 0 = left, 1 = right
//   AUD_DACDAT     out  serial data, MSB first
//   sample_strobe  out  one-cycle pulse when a mix sample is latched
//   clip           out  1 when the last latched sample was clamped
module square_voice_bank_dac #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned PERIOD_W   = 21,
  parameter int unsigned AMP_W      = 16,
  parameter int unsigned MCLK_DIV   = 2,
  parameter int unsigned BCLK_DIV   = 2
) (
  input  logic                           CLOCK_50_B5B,
  input  logic                           RESET_N,
  input  logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  input  logic [NUM_VOICES*AMP_W-1:0]    voice_amp,
  input  logic [NUM_VOICES-1:0]          voice_load,
  input  logic [NUM_VOICES-1:0]          voice_enable,
  output logic                           AUD_XCK,
  output logic                           AUD_BCLK,
  output logic                           AUD_DACLRCK,
  output logic                           AUD_DACDAT,
  output logic                           sample_strobe,
  output logic                           clip
);

  localparam int unsigned HALF_BCLK  = MCLK_DIV * BCLK_DIV;
  localparam int unsigned MCNT_W     = $clog2(MCLK_DIV + 1);
  localparam int unsigned BCNT_W     = $clog2(HALF_BCLK + 1);
  localparam int unsigned BIDX_W     = $clog2(2 * SAMPLE_W);
  localparam int unsigned VOICE_BITS = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 0;
`ifdef MIX_SATURATE_EN
  // Full-precision mix so overflow can be detected before clamping.
  localparam int unsigned MIX_W = SAMPLE_W + VOICE_BITS + 1;
  localparam logic signed [MIX_W-1:0] SAT_MAX =
    {{(MIX_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [MIX_W-1:0] SAT_MIN =
    {{(MIX_W - SAMPLE_W + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};
`else
  // Wrapping mix: modular arithmetic in SAMPLE_W bits equals the low bits
  // of the wide sum, so the wide sum is never built.
  localparam int unsigned MIX_W = SAMPLE_W;
`endif

  // Per-voice state
  logic [PERIOD_W-1:0] r_period_q [NUM_VOICES];
  logic [AMP_W-1:0]    r_amp_q    [NUM_VOICES];
  logic [PERIOD_W-1:0] r_cnt      [NUM_VOICES];
  logic                r_phase    [NUM_VOICES];

  // Mixer
  logic signed [MIX_W-1:0] w_sum;
  logic signed [MIX_W-1:0] r_mix_q;
  logic [SAMPLE_W-1:0]     w_sample;
  logic                    w_clip;

  // Clock generation
  logic [MCNT_W-1:0] r_mcnt;
  logic [BCNT_W-1:0] r_bcnt;
  logic              r_xck;
  logic              r_bclk;
  logic              w_bclk_fall;

  // Serializer
  logic [BIDX_W-1:0]   r_bidx;
  logic [SAMPLE_W-1:0] r_hold;
  logic [SAMPLE_W-1:0] r_shift;
  logic                r_dat;
  logic                r_lrck;
  logic                r_strobe;
  logic                r_clip;

  // Voice oscillators; a load takes priority over a wrap in the same cycle.
  always_ff @(posedge CLOCK_50_B5B or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        r_period_q[i] <= '0;
        r_amp_q[i]    <= '0;
        r_cnt[i]      <= '0;
        r_phase[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        if (voice_load[i]) begin
          r_period_q[i] <= voice_period[i*PERIOD_W +: PERIOD_W];
          r_amp_q[i]    <= voice_amp[i*AMP_W +: AMP_W];
          r_cnt[i]      <= '0;
          r_phase[i]    <= 1'b1;
        end else if (r_period_q[i] != '0) begin
          if (r_cnt[i] == r_period_q[i] - PERIOD_W'(1)) begin
            r_cnt[i]   <= '0;
            r_phase[i] <= ~r_phase[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + PERIOD_W'(1);
          end
        end
      end
    end
  end

  // Signed sum of active voices; amplitudes are unsigned so zero-extend.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (voice_enable[i] && (r_period_q[i] != '0)) begin
        if (r_phase[i]) w_sum = w_sum + MIX_W'(r_amp_q[i]);
        else            w_sum = w_sum - MIX_W'(r_amp_q[i]);
      end
    end
  end

  always_ff @(posedge CLOCK_50_B5B or negedge RESET_N) begin
    if (!RESET_N) r_mix_q <= '0;
    else          r_mix_q <= w_sum;
  end

`ifdef MIX_SATURATE_EN
  // Clamp to the signed SAMPLE_W range.
  always_comb begin
    w_sample = r_mix_q[SAMPLE_W-1:0];
    w_clip   = 1'b0;
    if (r_mix_q > SAT_MAX) begin
      w_sample = {1'b0, {(SAMPLE_W - 1){1'b1}}};
      w_clip   = 1'b1;
    end else if (r_mix_q < SAT_MIN) begin
      w_sample = {1'b1, {(SAMPLE_W - 1){1'b0}}};
      w_clip   = 1'b1;
    end
  end
`else
  assign w_sample = r_mix_q;
  assign w_clip   = 1'b0;
`endif

  // Master clock and bit clock dividers, both free-running from reset.
  always_ff @(posedge CLOCK_50_B5B or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mcnt <= '0;
      r_xck  <= 1'b0;
      r_bcnt <= '0;
      r_bclk <= 1'b0;
    end else begin
      if (r_mcnt == MCNT_W'(MCLK_DIV - 1)) begin
        r_mcnt <= '0;
        r_xck  <= ~r_xck;
      end else begin
        r_mcnt <= r_mcnt + MCNT_W'(1);
      end
      if (r_bcnt == BCNT_W'(HALF_BCLK - 1)) begin
        r_bcnt <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_bcnt <= r_bcnt + BCNT_W'(1);
      end
    end
  end

  // High in the cycle where the registered bit clock goes 1 -> 0.
  assign w_bclk_fall = (r_bcnt == BCNT_W'(HALF_BCLK - 1)) && r_bclk;

  // Serializer: r_hold keeps the latched sample so the right word repeats it.
  always_ff @(posedge CLOCK_50_B5B or negedge RESET_N) begin
    if (!RESET_N) begin
      r_bidx   <= '0;
      r_hold   <= '0;
      r_shift  <= '0;
      r_dat    <= 1'b0;
      r_lrck   <= 1'b0;
      r_strobe <= 1'b0;
      r_clip   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_bclk_fall) begin
        r_lrck <= (r_bidx >= BIDX_W'(SAMPLE_W));
        if (r_bidx == BIDX_W'(2 * SAMPLE_W - 1)) r_bidx <= '0;
        else                                     r_bidx <= r_bidx + BIDX_W'(1);
        if (r_bidx == '0) begin
          r_hold   <= w_sample;
          r_shift  <= {w_sample[SAMPLE_W-2:0], 1'b0};
          r_dat    <= w_sample[SAMPLE_W-1];
          r_strobe <= 1'b1;
          r_clip   <= w_clip;
        end else if (r_bidx == BIDX_W'(SAMPLE_W)) begin
          r_shift <= {r_hold[SAMPLE_W-2:0], 1'b0};
          r_dat   <= r_hold[SAMPLE_W-1];
        end else begin
          r_shift <= {r_shift[SAMPLE_W-2:0], 1'b0};
          r_dat   <= r_shift[SAMPLE_W-1];
        end
      end
    end
  end

  assign AUD_XCK       = r_xck;
  assign AUD_BCLK      = r_bclk;
  assign AUD_DACLRCK   = r_lrck;
  assign AUD_DACDAT    = r_dat;
  assign sample_strobe = r_strobe;
  assign clip          = r_clip;

endmodule

// File: tb/tb_square_voice_bank_dac.sv
// Directed bench for square_voice_bank_dac: a 24-bit instance (23-bit amps)
// for timing, mixing and serialization, and an 18-bit instance for clipping.
module tb_square_voice_bank_dac;

  localparam int unsigned NV      = 4;
  localparam int unsigned PW      = 21;
  localparam int unsigned AW      = 23;
  localparam int unsigned AW18    = 16;
  localparam int          BIT_CYC = 8;

`ifdef MIX_SATURATE_EN
  localparam logic [17:0] SAT_EXP  = 18'h1FFFF;
  localparam logic        CLIP_EXP = 1'b1;
`else
  localparam logic [17:0] SAT_EXP  = 18'h3FFFC;
  localparam logic        CLIP_EXP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NV*PW-1:0]   vp,  vp18;
  logic [NV*AW-1:0]   va;
  logic [NV*AW18-1:0] va18;
  logic [NV-1:0]      vl, ve, vl18, ve18;
  logic xck, bclk, lrck, dat, strb, clp;
  logic xck18, bclk18, lrck18, dat18, strb18, clp18;

  int checks   = 0;
  int failures = 0;

  square_voice_bank_dac #(
    .NUM_VOICES(NV), .SAMPLE_W(24), .PERIOD_W(PW), .AMP_W(AW),
    .MCLK_DIV(2), .BCLK_DIV(2)
  ) u_dut (
    .CLOCK_50_B5B(clk), .RESET_N(rst_n),
    .voice_period(vp), .voice_amp(va), .voice_load(vl), .voice_enable(ve),
    .AUD_XCK(xck), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat),
    .sample_strobe(strb), .clip(clp)
  );

  square_voice_bank_dac #(
    .NUM_VOICES(NV), .SAMPLE_W(18), .PERIOD_W(PW), .AMP_W(AW18),
    .MCLK_DIV(2), .BCLK_DIV(2)
  ) u_dut18 (
    .CLOCK_50_B5B(clk), .RESET_N(rst_n),
    .voice_period(vp18), .voice_amp(va18), .voice_load(vl18), .voice_enable(ve18),
    .AUD_XCK(xck18), .AUD_BCLK(bclk18), .AUD_DACLRCK(lrck18), .AUD_DACDAT(dat18),
    .sample_strobe(strb18), .clip(clp18)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for the next sample strobe, sampling on falling clock edges.
  task automatic wait_strobe(input bit sel18, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      seen = sel18 ? strb18 : strb;
    end
    check1(tag, seen, 1'b1);
  endtask

  // Called at the strobe sample point; collects one bit per BCLK period.
  task automatic capture(input bit sel18, input int nbits,
                         output logic [47:0] dv, output logic [47:0] lv);
    dv = '0;
    lv = '0;
    for (int k = 0; k < nbits; k++) begin
      if (k != 0) repeat (BIT_CYC) @(negedge clk);
      dv[nbits-1-k] = sel18 ? dat18 : dat;
      lv[nbits-1-k] = sel18 ? lrck18 : lrck;
    end
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] dv;
    logic [47:0] lv;
    int n_per;
    int lr_hi;
    int lr_first;
    int dat_ones;

    vp = '0; va = '0; vl = '0; ve = '0;
    vp18 = '0; va18 = '0; vl18 = '0; ve18 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_vec("rst_outputs", 64'({xck, bclk, lrck, dat, strb, clp}), 64'd0);
    check_int("rst_mix", int'(u_dut.r_mix_q), 0);

    // Release at a falling edge; the next rising edge is cycle 1.
    rst_n = 1'b1;
    @(negedge clk);
    check1("c1_xck", xck, 1'b0);
    @(negedge clk);
    check1("c2_xck", xck, 1'b1);
    repeat (2) @(negedge clk);
    check1("c4_bclk", bclk, 1'b1);
    check1("c4_xck", xck, 1'b0);
    repeat (3) @(negedge clk);
    check1("c7_bclk", bclk, 1'b1);
    check1("c7_strobe", strb, 1'b0);
    @(negedge clk);
    check1("c8_bclk", bclk, 1'b0);
    check1("c8_strobe", strb, 1'b1);
    check1("c8_lrck", lrck, 1'b0);
    check1("c8_dat", dat, 1'b0);

    // One idle frame: period, LRCK placement and silent data.
    n_per = 0; lr_hi = 0; lr_first = -1; dat_ones = 0;
    for (int n = 1; n <= 500 && n_per == 0; n++) begin
      @(negedge clk);
      if (strb) n_per = n;
      else begin
        if (lrck) begin
          lr_hi++;
          if (lr_first < 0) lr_first = n;
        end
        if (dat) dat_ones++;
      end
    end
    check_int("strobe_period", n_per, 384);
    check_int("lrck_first_high", lr_first, 192);
    check_int("lrck_high_cycles", lr_hi, 192);
    check_int("idle_dat_ones", dat_ones, 0);

    // Voice 0: period 5, amp 1000.
    vp[0*PW +: PW] = 21'd5;
    va[0*AW +: AW] = 23'd1000;
    vl = 4'b0001;
    ve = 4'b0001;
    @(negedge clk);
    vl = 4'b0000;
    check_int("v0_mix_at_load", int'(u_dut.r_mix_q), 0);
    @(negedge clk);
    check_int("v0_mix_l1", int'(u_dut.r_mix_q), 1000);
    repeat (4) @(negedge clk);
    check_int("v0_mix_l5", int'(u_dut.r_mix_q), 1000);
    @(negedge clk);
    check_int("v0_mix_l6", int'(u_dut.r_mix_q), -1000);
    repeat (4) @(negedge clk);
    check_int("v0_mix_l10", int'(u_dut.r_mix_q), -1000);
    @(negedge clk);
    check_int("v0_mix_l11", int'(u_dut.r_mix_q), 1000);

    // Voices 0 and 1 loaded together, then voice 1 reloaded mid-wave.
    vp[0*PW +: PW] = 21'd3;
    vp[1*PW +: PW] = 21'd3;
    va[0*AW +: AW] = 23'd300;
    va[1*AW +: AW] = 23'd200;
    vl = 4'b0011;
    ve = 4'b0011;
    @(negedge clk);
    vl = 4'b0000;
    @(negedge clk);
    check_int("v01_mix_l1", int'(u_dut.r_mix_q), 500);
    repeat (2) @(negedge clk);
    check_int("v01_mix_l3", int'(u_dut.r_mix_q), 500);
    vl = 4'b0010;
    @(negedge clk);
    vl = 4'b0000;
    check_int("v01_mix_l4", int'(u_dut.r_mix_q), -500);
    @(negedge clk);
    check_int("v1_reload_l5", int'(u_dut.r_mix_q), -100);
    repeat (2) @(negedge clk);
    check_int("v1_reload_l7", int'(u_dut.r_mix_q), 500);
    @(negedge clk);
    check_int("v1_reload_l8", int'(u_dut.r_mix_q), 100);

    // 18-bit instance: four voices at full amplitude, all in + phase.
    for (int i = 0; i < int'(NV); i++) begin
      vp18[i*PW +: PW]     = 21'd1000;
      va18[i*AW18 +: AW18] = 16'hFFFF;
    end
    vl18 = 4'b1111;
    ve18 = 4'b1111;
    @(negedge clk);
    vl18 = 4'b0000;
    @(negedge clk);
    wait_strobe(1'b1, "sat_strobe_seen");
    check1("sat_clip", clp18, CLIP_EXP);
    capture(1'b1, 36, dv, lv);
    check_vec("sat_left_word", 64'(dv[35:18]), 64'(SAT_EXP));
    check_vec("sat_right_word", 64'(dv[17:0]), 64'(SAT_EXP));
    ve18 = 4'b0000;
    wait_strobe(1'b1, "sat_quiet_strobe_seen");
    check1("sat_clip_cleared", clp18, 1'b0);
    check1("sat_quiet_msb", dat18, 1'b0);

    // Serialize -8388607 (0x800001): load right after a latch, period 200,
    // so the next latch falls in the negative half-wave.
    wait_strobe(1'b0, "ser_sync_strobe_seen");
    vp[0*PW +: PW] = 21'd200;
    va[0*AW +: AW] = 23'h7FFFFF;
    vl = 4'b0001;
    ve = 4'b0001;
    @(negedge clk);
    vl = 4'b0000;
    wait_strobe(1'b0, "ser_strobe_seen");
    check1("ser_clip", clp, 1'b0);
    capture(1'b0, 48, dv, lv);
    check_vec("ser_left_word", 64'(dv[47:24]), 64'h800001);
    check_vec("ser_right_word", 64'(dv[23:0]), 64'h800001);
    check_vec("ser_lrck_pattern", 64'(lv), 64'h0000_00FF_FFFF);

    // Reset in the middle of the right word.
    wait_strobe(1'b0, "rst_sync_strobe_seen");
    repeat (30 * BIT_CYC) @(negedge clk);
    check1("pre_rst_lrck", lrck, 1'b1);
    rst_n = 1'b0;
    #1;
    check_vec("midrst_outputs",
              64'({xck, bclk, lrck, dat, strb, clp, xck18, bclk18, lrck18, dat18, strb18, clp18}),
              64'd0);
    check_int("midrst_mix", int'(u_dut.r_mix_q), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    check1("post_rst_c7_strobe", strb, 1'b0);
    check1("post_rst_c7_bclk", bclk, 1'b1);
    @(negedge clk);
    check1("post_rst_c8_strobe", strb, 1'b1);
    check1("post_rst_c8_lrck", lrck, 1'b0);
    check1("post_rst_c8_bclk", bclk, 1'b0);
    check1("post_rst_c8_dat", dat, 1'b0);
    check_int("post_rst_mix", int'(u_dut.r_mix_q), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
